sqrt_out_packer: RTL and testbench
==================================

# sqrt_out_packer

Downstream stage of the unsigned 32-bit square-root pipeline. Consumes the root stream (`vld_out`/`y[15:0]`) and packs consecutive 16-bit roots into 32-bit words. Buffers the words in a small FIFO and presents them on a valid/ready master port toward the bus or memory writer. The FIFO absorbs back-pressure because the root pipeline cannot be stalled. Drops are flagged rather than silently lost.

## Interface
- `DEPTH`, 8: FIFO depth in words; power of two, ≥2.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `vld_in`  in  1  root valid; connect to the sqrt pipeline's `vld_out`.
- `y_in`  in  16  root value; connect to `y`.
- `flush`  in  1  single-cycle pulse; emits a pending half-word.
- `clr_ovf`  in  1  clears `ovf`.
- `m_valid`  out  1  head word available.
- `m_ready`  in  1  consumer accepts the head word.
- `m_data`  out  32  packed word: first root in [15:0], second root in [31:16].
- `m_odd`  out  1  word carries only the low half; [31:16] are 0.
- `m_level`  out  $clog2(DEPTH)+1  number of words currently stored.
- `ovf`  out  1  sticky flag: a word was dropped.

## Operation
- **Packer state.** Two states, EMPTY_HALF and HAVE_LOW, plus a 16-bit low-half register.
- **EMPTY_HALF + `vld_in`:**
  - Capture `y_in` as the low half.
  - Go to HAVE_LOW.
- **HAVE_LOW + `vld_in`:**
  - Push `{y_in, low}` with odd=0.
  - Go to EMPTY_HALF.
- **HAVE_LOW + `flush`, no `vld_in`:**
  - Push `{16'h0, low}` with odd=1.
  - Go to EMPTY_HALF.
- **EMPTY_HALF + `flush` + `vld_in`:**
  - Push `{16'h0, y_in}` with odd=1.
  - Stay in EMPTY_HALF.
- **HAVE_LOW + `flush` + `vld_in`:** normal pair push. `flush` is satisfied and no extra word is produced.
- **`flush` in EMPTY_HALF without `vld_in`:** no-op.
- **Push rate.** At most one push per cycle.
- **Pop.** A pop occurs when `m_valid && m_ready`.
- **FIFO full, push without pop in the same cycle:**
  - The word is dropped and `ovf` is set.
  - The packer still advances state, so pairing stays aligned to the input stream.
- **FIFO full, push and pop in the same cycle:** both are performed. No drop; `m_level` is unchanged.
- **FIFO empty, push and pop in the same cycle:** impossible, because `m_valid` is 0.
- **`ovf` priority.** `ovf` set has priority over `clr_ovf` in the same cycle.
- **Pointers.** $clog2(DEPTH)+1-bit read/write pointers; wrap naturally.
  - Full: MSBs differ and the remaining bits are equal.
  - Empty: pointers equal.

## Timing
- **Reset values (all outputs):**
  - `m_valid`=0, `m_data`=0, `m_odd`=0, `m_level`=0, `ovf`=0.
  - Packer state EMPTY_HALF; low register 0; both pointers 0.
- **Reset mid-operation:** all buffered words and any pending half are discarded.
- **Latency:** a push sampled at edge N gives `m_valid`=1, with `m_data`/`m_odd` showing that word, after edge N when the FIFO was empty. This is 1 cycle from the completing sample.
- **Output hold:** `m_data`/`m_odd` are registered head copies and are stable while `m_valid && !m_ready`.
- **Last value:** when the FIFO empties, `m_data`/`m_odd` hold their last value and only `m_valid` drops.
- **Throughput:**
  - Full rate on input (1 root/cycle) yields 1 word per 2 cycles.
  - Full rate on output is 1 word/cycle with `m_ready` held high.
- **`m_level`:** registered; reflects pushes and pops of edge N after edge N.

## Structure
- **Package `sqrt_pkg`:**
  - `Y_W`=16, `WORD_W`=32.
  - Typedef `pack_entry_t` = {odd, data[31:0]}.
  - Packer state enum.
- **Sub-module `sync_fifo`:**
  - Generic single-clock FIFO, parameter `DEPTH` and entry width.
  - Registered head output, push/pop, full/empty/level.
- **Top:** packer FSM plus the `ovf` logic. `sync_fifo` is reusable by the upstream input feeder.

## Test plan
- **Pair packing:** `m_ready`=1; `y_in`=16 then 15 on consecutive cycles -> one word `m_data`=0x000F_0010, `m_odd`=0. `m_valid` is high for exactly 1 cycle, starting 1 cycle after the second sample.
- **Flush of pending half:** `y_in`=46340 (0xB504), then `flush` 3 cycles later -> `m_data`=0x0000_B504, `m_odd`=1. A second `flush` produces no word.
- **Flush with `vld_in`, EMPTY_HALF:** `flush` and `vld_in` together with `y_in`=65535 -> `m_data`=0x0000_FFFF, `m_odd`=1. The next two roots 1, 2 give 0x0002_0001.
- **Overflow:** DEPTH=8, `m_ready`=0, 18 roots 0..17.
  - `m_level`=8 and `ovf`=1.
  - On draining, exactly 8 words 0x0001_0000 … 0x000F_000E are read; 0x0011_0010 is lost.
  - `clr_ovf` clears `ovf`.
- **Full with simultaneous push/pop:** fill to 8, then assert `m_ready` in the same cycle a pair completes -> `ovf` stays 0, `m_level` stays 8, and word order is preserved.
- **Reset mid-stream:** with 3 words stored and a half pending, pulse `rst` asynchronously -> all outputs read 0 immediately. The next roots 7, 9 produce 0x0009_0007.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared types for the square-root output packer: root/word widths, FIFO entry, packer state.
// Pure declarations; no latency or flow control of its own.
package sqrt_pkg;

   localparam int Y_W    = 16;
   localparam int WORD_W = 32;

   typedef struct packed {
      logic              odd;
      logic [WORD_W-1:0] data;
   } pack_entry_t;

   typedef enum logic {
      EMPTY_HALF = 1'b0,
      HAVE_LOW   = 1'b1
   } pack_state_t;

   function automatic pack_entry_t make_entry(input logic odd,
                                              input logic [Y_W-1:0] hi,
                                              input logic [Y_W-1:0] lo);
      pack_entry_t e;
      e.odd  = odd;
      e.data = {hi, lo};
      return e;
   endfunction

endpackage

// File: rtl/sqrt_out_packer_if.sv
// Root-stream input plus packed-word valid/ready output of the packer.
// master = packer side, slave = root source / word consumer side.
interface sqrt_out_packer_if #(
   parameter int DEPTH = 8
);
   import sqrt_pkg::*;

   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic              vld_in;
   logic [Y_W-1:0]    y_in;
   logic              flush;
   logic              clr_ovf;
   logic              m_valid;
   logic              m_ready;
   logic [WORD_W-1:0] m_data;
   logic              m_odd;
   logic [LVL_W-1:0]  m_level;
   logic              ovf;

   modport master (
      input  vld_in, y_in, flush, clr_ovf, m_ready,
      output m_valid, m_data, m_odd, m_level, ovf
   );

   modport slave (
      output vld_in, y_in, flush, clr_ovf, m_ready,
      input  m_valid, m_data, m_odd, m_level, ovf
   );

endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with a registered head copy; 1-cycle push-to-head latency.
// A push while full is accepted only if a pop happens on the same edge; otherwise it is ignored.
module sync_fifo #(
   parameter  int DEPTH = 8,
   parameter  int W     = 33,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic [W-1:0]  push_dat_i,
   input  logic          pop_i,
   output logic [W-1:0]  head_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [LW-1:0] level_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [LW-1:0] wr_ptr_q, wr_ptr_d;
   logic [LW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic [W-1:0]  head_q, head_d;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q + LW'(do_push);
      rd_ptr_d = rd_ptr_q + LW'(do_pop);
      level_d  = level_q + LW'(do_push) - LW'(do_pop);
      head_d   = head_q;
      // Head refreshes only when it changes; with nothing left it keeps the last word.
      if (do_pop || empty_o) begin
         if (wr_ptr_q == rd_ptr_d) begin
            if (do_push) begin
               head_d = push_dat_i;
            end
         end else begin
            head_d = mem_q[rd_ptr_d[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         head_q   <= head_d;
      end
   end

   assign head_o  = head_q;
   assign level_o = level_q;

endmodule

// File: rtl/sqrt_out_packer.sv
// Packs pairs of 16-bit roots into 32-bit words and buffers them; word visible 1 cycle after it completes.
// Input cannot stall: a word arriving at a full FIFO with no pop is dropped and sets sticky ovf.
module sqrt_out_packer
   import sqrt_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input logic                clk,
   input logic                rst,
   sqrt_out_packer_if.master  bus
);

   localparam int LW = $clog2(DEPTH) + 1;

   pack_state_t    state_q;
   logic [Y_W-1:0] low_q;
   logic           ovf_q;

   logic           push;
   pack_entry_t    push_entry;
   pack_entry_t    head;
   logic           pop;
   logic           fifo_full;
   logic           fifo_empty;
   logic [LW-1:0]  fifo_level;

   always_comb begin
      push       = 1'b0;
      push_entry = '0;
      if (bus.vld_in) begin
         // With a low half pending, flush is satisfied by the normal pair.
         if (state_q == HAVE_LOW) begin
            push       = 1'b1;
            push_entry = make_entry(1'b0, bus.y_in, low_q);
         end else if (bus.flush) begin
            push       = 1'b1;
            push_entry = make_entry(1'b1, '0, bus.y_in);
         end
      end else if (bus.flush && state_q == HAVE_LOW) begin
         push       = 1'b1;
         push_entry = make_entry(1'b1, '0, low_q);
      end
   end

   assign pop = !fifo_empty && bus.m_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY_HALF;
         low_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         if (bus.vld_in) begin
            if (state_q == EMPTY_HALF && !bus.flush) begin
               state_q <= HAVE_LOW;
               low_q   <= bus.y_in;
            end else begin
               state_q <= EMPTY_HALF;
            end
         end else if (bus.flush) begin
            state_q <= EMPTY_HALF;
         end

         // The packer advances even when the word is dropped, keeping pairs aligned.
         if (push && fifo_full && !pop) begin
            ovf_q <= 1'b1;
         end else if (bus.clr_ovf) begin
            ovf_q <= 1'b0;
         end
      end
   end

   sync_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(pack_entry_t))
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .push_dat_i (push_entry),
      .pop_i      (pop),
      .head_o     (head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .level_o    (fifo_level)
   );

   assign bus.m_valid = !fifo_empty;
   assign bus.m_data  = head.data;
   assign bus.m_odd   = head.odd;
   assign bus.m_level = fifo_level;
   assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_sqrt_out_packer.sv
// Bench for sqrt_out_packer: directed vector table, hand-written corner sequences, random run vs queue model.
module tb_sqrt_out_packer;
   import sqrt_pkg::*;

   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   sqrt_out_packer_if #(.DEPTH(DEPTH)) bus ();

   sqrt_out_packer #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Reference model: a queue of stored words, an optional pending low half, sticky ovf.
   pack_entry_t mq[$];
   bit          m_pend;
   logic [15:0] m_low;
   bit          m_ovf;
   pack_entry_t m_shown;

   typedef struct {
      logic        vld;
      logic [15:0] y;
      logic        fl;
      logic        clr;
      logic        rdy;
      logic        ev;
      logic [31:0] ed;
      logic        eo;
      logic [3:0]  el;
      logic        eovf;
   } vec_t;

   vec_t tbl[13];

   function automatic vec_t mkv(logic vld, logic [15:0] y, logic fl, logic clr, logic rdy,
                                logic ev, logic [31:0] ed, logic eo, logic [3:0] el, logic eovf);
      vec_t v;
      v.vld = vld; v.y = y; v.fl = fl; v.clr = clr; v.rdy = rdy;
      v.ev = ev; v.ed = ed; v.eo = eo; v.el = el; v.eovf = eovf;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pend  = 0;
      m_low   = '0;
      m_ovf   = 0;
      m_shown = '0;
   endtask

   task automatic model_edge(input logic vld, input logic [15:0] y, input logic fl,
                             input logic clr, input logic rdy);
      bit          do_push = 0;
      bit          drop    = 0;
      pack_entry_t w       = '0;
      bit          do_pop  = (mq.size() > 0) && rdy;
      if (vld && m_pend) begin
         w = '{odd: 1'b0, data: {y, m_low}}; do_push = 1; m_pend = 0;
      end else if (vld && fl) begin
         w = '{odd: 1'b1, data: {16'h0, y}}; do_push = 1;
      end else if (vld) begin
         m_low = y; m_pend = 1;
      end else if (fl && m_pend) begin
         w = '{odd: 1'b1, data: {16'h0, m_low}}; do_push = 1; m_pend = 0;
      end
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
         if (mq.size() < DEPTH) mq.push_back(w);
         else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (mq.size() > 0) m_shown = mq[0];
   endtask

   task automatic step(input logic vld, input logic [15:0] y, input logic fl,
                       input logic clr, input logic rdy);
      bus.vld_in  = vld;
      bus.y_in    = y;
      bus.flush   = fl;
      bus.clr_ovf = clr;
      bus.m_ready = rdy;
      @(posedge clk);
      model_edge(vld, y, fl, clr, rdy);
      #1;
      chk("model_valid", 32'(bus.m_valid), 32'(mq.size() > 0));
      chk("model_level", 32'(bus.m_level), 32'(mq.size()));
      chk("model_ovf",   32'(bus.ovf),     32'(m_ovf));
      chk("model_data",  bus.m_data,       m_shown.data);
      chk("model_odd",   32'(bus.m_odd),   32'(m_shown.odd));
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 16'h0, 1'b0, 1'b0, rdy);
   endtask

   initial begin
      logic [31:0] ew;
      int          thr;

      bus.vld_in = 0; bus.y_in = '0; bus.flush = 0; bus.clr_ovf = 0; bus.m_ready = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(bus.m_valid), 32'd0);
      chk("rst_data",  bus.m_data,       32'd0);
      chk("rst_odd",   32'(bus.m_odd),   32'd0);
      chk("rst_level", 32'(bus.m_level), 32'd0);
      chk("rst_ovf",   32'(bus.ovf),     32'd0);
      rst = 1'b0;

      // vld, y, flush, clr, rdy | valid, data, odd, level, ovf (sampled just after the edge)
      tbl[0]  = mkv(1, 16'd16,   0, 0, 1,  0, 32'h0000_0000, 0, 0, 0);
      tbl[1]  = mkv(1, 16'd15,   0, 0, 1,  1, 32'h000F_0010, 0, 1, 0);
      tbl[2]  = mkv(0, 16'd0,    0, 0, 1,  0, 32'h000F_0010, 0, 0, 0);
      tbl[3]  = mkv(1, 16'hB504, 0, 0, 1,  0, 32'h000F_0010, 0, 0, 0);
      tbl[4]  = mkv(0, 16'd0,    0, 0, 1,  0, 32'h000F_0010, 0, 0, 0);
      tbl[5]  = mkv(0, 16'd0,    0, 0, 1,  0, 32'h000F_0010, 0, 0, 0);
      tbl[6]  = mkv(0, 16'd0,    1, 0, 0,  1, 32'h0000_B504, 1, 1, 0);
      tbl[7]  = mkv(0, 16'd0,    1, 0, 1,  0, 32'h0000_B504, 1, 0, 0);
      tbl[8]  = mkv(0, 16'd0,    0, 0, 1,  0, 32'h0000_B504, 1, 0, 0);
      tbl[9]  = mkv(1, 16'hFFFF, 1, 0, 0,  1, 32'h0000_FFFF, 1, 1, 0);
      tbl[10] = mkv(1, 16'd1,    0, 0, 1,  0, 32'h0000_FFFF, 1, 0, 0);
      tbl[11] = mkv(1, 16'd2,    0, 0, 1,  1, 32'h0002_0001, 0, 1, 0);
      tbl[12] = mkv(0, 16'd0,    0, 0, 1,  0, 32'h0002_0001, 0, 0, 0);

      for (int i = 0; i < 13; i++) begin
         step(tbl[i].vld, tbl[i].y, tbl[i].fl, tbl[i].clr, tbl[i].rdy);
         chk($sformatf("vec%0d_valid", i), 32'(bus.m_valid), 32'(tbl[i].ev));
         chk($sformatf("vec%0d_data", i),  bus.m_data,       tbl[i].ed);
         chk($sformatf("vec%0d_odd", i),   32'(bus.m_odd),   32'(tbl[i].eo));
         chk($sformatf("vec%0d_level", i), 32'(bus.m_level), 32'(tbl[i].el));
         chk($sformatf("vec%0d_ovf", i),   32'(bus.ovf),     32'(tbl[i].eovf));
      end

      // Overflow: 18 roots with no consumer; the ninth word is lost.
      for (int i = 0; i < 18; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
      chk("ovf_level", 32'(bus.m_level), 32'd8);
      chk("ovf_flag",  32'(bus.ovf),     32'd1);
      for (int i = 0; i < 8; i++) begin
         ew = {16'(2 * i + 1), 16'(2 * i)};
         chk("ovf_drain_valid", 32'(bus.m_valid), 32'd1);
         chk("ovf_drain_data",  bus.m_data,       ew);
         idle(1'b1);
      end
      chk("ovf_drained", 32'(bus.m_valid), 32'd0);
      chk("ovf_still_set", 32'(bus.ovf), 32'd1);
      step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      chk("ovf_cleared", 32'(bus.ovf), 32'd0);

      // Full FIFO, pair completes on the same edge as a pop.
      for (int i = 0; i < 16; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
      chk("full_level", 32'(bus.m_level), 32'd8);
      step(1'b1, 16'd100, 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'd101, 1'b0, 1'b0, 1'b1);
      chk("pp_ovf",   32'(bus.ovf),     32'd0);
      chk("pp_level", 32'(bus.m_level), 32'd8);
      for (int i = 1; i < 9; i++) begin
         ew = (i == 8) ? 32'h0065_0064 : {16'(2 * i + 1), 16'(2 * i)};
         chk("pp_order", bus.m_data, ew);
         idle(1'b1);
      end
      chk("pp_empty", 32'(bus.m_valid), 32'd0);

      // Asynchronous reset with three words stored and a half pending.
      for (int i = 0; i < 7; i++) step(1'b1, 16'(i + 40), 1'b0, 1'b0, 1'b0);
      chk("pre_rst_level", 32'(bus.m_level), 32'd3);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", 32'(bus.m_valid), 32'd0);
      chk("arst_data",  bus.m_data,       32'd0);
      chk("arst_odd",   32'(bus.m_odd),   32'd0);
      chk("arst_level", 32'(bus.m_level), 32'd0);
      chk("arst_ovf",   32'(bus.ovf),     32'd0);
      model_reset();
      #1 rst = 1'b0;
      step(1'b1, 16'd7, 1'b0, 1'b0, 1'b1);
      step(1'b1, 16'd9, 1'b0, 1'b0, 1'b1);
      chk("post_rst_word", bus.m_data, 32'h0009_0007);
      chk("post_rst_odd",  32'(bus.m_odd), 32'd0);

      // Random traffic with varying consumer pressure.
      for (int p = 0; p < 6; p++) begin
         thr = (p % 3 == 0) ? 15 : ((p % 3 == 1) ? 95 : 50);
         for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 16'($urandom), ($urandom % 8) == 0,
                 ($urandom % 16) == 0, ($urandom % 100) < thr);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
